// File: rtl/spi_resp_pkg.sv
// Shared opcodes, FSM states and address width for the SPI memory responder.
package spi_resp_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    localparam int ADDR_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings spi_sclk, spi_cs_n and the IO lines into the clk domain and
// flags sclk rising/falling edges aligned with the synchronized IO data.
module spi_edge_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic [3:0] spi_io_in,
    output logic       cs_n_s,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic [3:0] io_s
);

    logic [2:0] sclk_q;
    logic [1:0] cs_q;
    logic [3:0] io_m, io_q;

    // cs resets to "low" so a reset taken mid-transaction cannot be mistaken
    // for a deselect; the top waits for a genuine cs high before re-arming.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            io_m   <= '0;
            io_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            cs_q   <= {cs_q[0], spi_cs_n};
            io_m   <= spi_io_in;
            io_q   <= io_m;
        end
    end

    assign cs_n_s    = cs_q[1];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign io_s      = io_q;

endmodule

// File: rtl/spi_mem_responder.sv
// PSRAM-style SPI/QSPI target backed by an internal byte array.
// Quad opcodes (0xEB/0x38) and the DUMMY phase exist only with SPI_RESP_QUAD_EN.
module spi_mem_responder
    import spi_resp_pkg::*;
#(
    parameter int MEM_BYTES    = 4096,
    parameter int DUMMY_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic [3:0]  spi_io_in,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    input  logic        load_en,
    input  logic [23:0] load_addr,
    input  logic [7:0]  load_data
);

    localparam int AW = $clog2(MEM_BYTES);

`ifdef SPI_RESP_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    logic [7:0] dummy_cnt_q;
`else
    localparam bit QUAD_EN = 1'b0;
    logic unused_cfg;
    assign unused_cfg = (DUMMY_CYCLES != 0);
`endif

    logic       cs_n_s, sclk_rise, sclk_fall;
    logic [3:0] io_s;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_io_in (spi_io_in),
        .cs_n_s    (cs_n_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .io_s      (io_s)
    );

    spi_state_e        state_q, state_d;
    logic              armed_q;
    logic              wr_q, quad_q;
    logic [4:0]        bit_cnt_q;
    logic [7:0]        sh_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        tx_cnt_q;
    logic [7:0]        tx_sh_q;
    logic [3:0]        io_out_q, io_oe_q;
    logic [7:0]        mem [MEM_BYTES];

    logic [7:0]    cmd_byte, wr_byte, rd_byte;
    logic [4:0]    step;
    logic          addr_done, byte_done, spi_we;
    logic [AW-1:0] addr_inc;
    logic          unused_load;

    assign unused_load = ^load_addr[ADDR_W-1:AW];

    assign step      = quad_q ? 5'd4 : 5'd1;
    assign cmd_byte  = {sh_q[6:0], io_s[0]};
    assign wr_byte   = quad_q ? {sh_q[3:0], io_s} : {sh_q[6:0], io_s[0]};
    assign addr_done = bit_cnt_q == (quad_q ? 5'd20 : 5'd23);
    assign byte_done = bit_cnt_q == (quad_q ? 5'd4 : 5'd7);
    assign addr_inc  = addr_q[AW-1:0] + 1'b1;
    // A new byte is fetched straight from the array on the first falling
    // edge of each byte; later bits come out of the shift register.
    assign rd_byte   = (tx_cnt_q == 3'd0) ? mem[addr_q[AW-1:0]] : tx_sh_q;
    assign spi_we    = !cs_n_s && (state_q == WDATA) && sclk_rise && byte_done;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_n_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (armed_q) state_d = CMD;
                CMD: begin
                    if (sclk_rise && bit_cnt_q == 5'd7) begin
                        case (cmd_byte)
                            CMD_READ, CMD_WRITE: state_d = ADDR;
                            CMD_QREAD, CMD_QWRITE: begin
                                if (QUAD_EN) state_d = ADDR;
                                else         state_d = IGNORE;
                            end
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (sclk_rise && addr_done) begin
                        if (wr_q) state_d = WDATA;
`ifdef SPI_RESP_QUAD_EN
                        else if (quad_q && DUMMY_CYCLES != 0) state_d = DUMMY;
`endif
                        else state_d = RDATA;
                    end
                end
`ifdef SPI_RESP_QUAD_EN
                DUMMY: if (sclk_rise && dummy_cnt_q == DUMMY_LAST) state_d = RDATA;
`endif
                RDATA, WDATA, IGNORE: state_d = state_q;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q   <= 1'b0;
            wr_q      <= 1'b0;
            quad_q    <= 1'b0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            tx_cnt_q  <= '0;
            tx_sh_q   <= '0;
            io_out_q  <= '0;
            io_oe_q   <= '0;
`ifdef SPI_RESP_QUAD_EN
            dummy_cnt_q <= '0;
`endif
        end else if (cs_n_s) begin
            // Deselect re-arms the block and drops any partial byte.
            armed_q   <= 1'b1;
            wr_q      <= 1'b0;
            quad_q    <= 1'b0;
            bit_cnt_q <= '0;
            tx_cnt_q  <= '0;
            io_out_q  <= '0;
            io_oe_q   <= '0;
        end else begin
            case (state_q)
                CMD: begin
                    if (sclk_rise) begin
                        sh_q      <= cmd_byte;
                        bit_cnt_q <= (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            wr_q   <= (cmd_byte == CMD_WRITE) || (cmd_byte == CMD_QWRITE);
                            quad_q <= QUAD_EN && ((cmd_byte == CMD_QREAD) || (cmd_byte == CMD_QWRITE));
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_q    <= quad_q ? {addr_q[ADDR_W-5:0], io_s}
                                            : {addr_q[ADDR_W-2:0], io_s[0]};
                        bit_cnt_q <= addr_done ? 5'd0 : bit_cnt_q + step;
`ifdef SPI_RESP_QUAD_EN
                        dummy_cnt_q <= '0;
`endif
                    end
                end
`ifdef SPI_RESP_QUAD_EN
                DUMMY: if (sclk_rise) dummy_cnt_q <= dummy_cnt_q + 8'd1;
`endif
                RDATA: begin
                    if (sclk_fall) begin
                        if (tx_cnt_q == 3'd0) addr_q <= ADDR_W'(addr_inc);
                        if (quad_q) begin
                            io_out_q <= rd_byte[7:4];
                            io_oe_q  <= 4'hF;
                            tx_sh_q  <= {rd_byte[3:0], 4'h0};
                            tx_cnt_q <= tx_cnt_q + 3'd4;
                        end else begin
                            io_out_q <= {2'b00, rd_byte[7], 1'b0};
                            io_oe_q  <= 4'b0010;
                            tx_sh_q  <= {rd_byte[6:0], 1'b0};
                            tx_cnt_q <= tx_cnt_q + 3'd1;
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        sh_q      <= wr_byte;
                        bit_cnt_q <= byte_done ? 5'd0 : bit_cnt_q + step;
                        if (byte_done) addr_q <= ADDR_W'(addr_inc);
                    end
                end
                default: ;
            endcase
        end
    end

    // Contents survive reset; the SPI write is ordered last so it wins a
    // same-address collision with the backdoor.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr[AW-1:0]] <= load_data;
        if (spi_we)  mem[addr_q[AW-1:0]]    <= wr_byte;
    end

    assign spi_io_out = io_out_q;
    assign spi_io_oe  = io_oe_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench: stimulus pushes expected read bytes, a monitor on spi_sclk
// collects returned bytes and checks spi_io_oe at every sampling edge.
`timescale 1ns/1ps
module tb_spi_mem_responder;

    localparam int HALF = 4;

`ifdef SPI_RESP_QUAD_EN
    localparam bit QUAD = 1'b1;
`else
    localparam bit QUAD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sclk = 1'b0;
    logic [3:0]  spi_io_in = 4'h0;
    logic [3:0]  spi_io_out, spi_io_oe;
    logic        load_en = 1'b0;
    logic [23:0] load_addr = '0;
    logic [7:0]  load_data = '0;

    always #5 clk = ~clk;

    spi_mem_responder #(.MEM_BYTES(4096), .DUMMY_CYCLES(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_io_in  (spi_io_in),
        .spi_io_out (spi_io_out),
        .spi_io_oe  (spi_io_oe),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    int         vec_cnt = 0;
    int         miss_cnt = 0;
    logic [7:0] exp_q[$];
    logic [3:0] exp_oe = 4'h0;
    bit         chk_zero = 1'b0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] want);
        vec_cnt++;
        if (act !== want) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: samples on the initiator's rising sclk, like a real host.
    initial begin : monitor
        logic [7:0] rx;
        logic [7:0] want;
        int         rx_n;
        rx = '0;
        rx_n = 0;
        forever begin
            @(posedge spi_sclk or posedge spi_cs_n);
            if (spi_cs_n) begin
                rx_n = 0;
            end else begin
                check4("oe", spi_io_oe, exp_oe);
                if (chk_zero) check4("out_zero", spi_io_out, 4'h0);
                if (exp_oe == 4'b0010) begin
                    rx = {rx[6:0], spi_io_out[1]};
                    rx_n += 1;
                end else if (exp_oe == 4'hF) begin
                    rx = {rx[3:0], spi_io_out};
                    rx_n += 4;
                end
                if (rx_n == 8) begin
                    rx_n = 0;
                    vec_cnt++;
                    if (exp_q.size() == 0) begin
                        miss_cnt++;
                        $display("FAIL rd_byte: got %h, expected nothing", rx);
                    end else begin
                        want = exp_q.pop_front();
                        if (rx !== want) begin
                            miss_cnt++;
                            $display("FAIL rd_byte: got %h, expected %h (t=%0t)", rx, want, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not finish, %0d vectors so far", vec_cnt);
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_edge(input logic [3:0] d);
        spi_io_in = d;
        wait_clk(HALF);
        spi_sclk = 1'b1;
        wait_clk(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sclk_edge({3'b000, b[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) sclk_edge({3'b000, a[i]});
    endtask

    task automatic send_addr_q(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sclk_edge(a[i*4 +: 4]);
    endtask

    task automatic cs_low();
        exp_oe = 4'h0;
        wait_clk(2);
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        exp_oe = 4'h0;
        spi_cs_n = 1'b1;
        wait_clk(4);
        check4("oe_after_cs", spi_io_oe, 4'h0);
        wait_clk(4);
    endtask

    task automatic load(input logic [23:0] a, input logic [7:0] d);
        load_addr = a;
        load_data = d;
        load_en = 1'b1;
        wait_clk(1);
        load_en = 1'b0;
    endtask

    task automatic single_read(input logic [23:0] a, input int nbytes);
        cs_low();
        send_byte(8'h03);
        send_addr(a);
        exp_oe = 4'b0010;
        repeat (nbytes * 8) sclk_edge(4'h0);
        cs_high();
    endtask

    initial begin : stim
        wait_clk(3);
        check4("rst_oe", spi_io_oe, 4'h0);
        check4("rst_out", spi_io_out, 4'h0);
        rst = 1'b0;
        wait_clk(4);
        check4("post_rst_oe", spi_io_oe, 4'h0);

        load(24'h000100, 8'hA5);
        load(24'h000101, 8'h5A);
        load(24'h000102, 8'h3C);
        load(24'hABC103, 8'hC3);   // upper bits fold away modulo depth
        load(24'h000010, 8'h00);
        load(24'h000011, 8'h00);
        load(24'h000012, 8'h99);
        load(24'h000FFF, 8'hE1);
        load(24'h000000, 8'h1E);

        // single read of preloaded bytes
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
        single_read(24'h000100, 4);

        // single write 11 22, then half a byte dropped by deselect
        cs_low();
        send_byte(8'h02);
        send_addr(24'h000010);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 0; i < 4; i++) sclk_edge(4'h1);
        cs_high();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h99);
        single_read(24'h000010, 3);

        // quad write across the top of memory
        cs_low();
        send_byte(8'h38);
        send_addr_q(24'h000FFF);
        sclk_edge(4'h7); sclk_edge(4'h7);
        sclk_edge(4'h8); sclk_edge(4'h8);
        cs_high();

        // quad read back with dummy phase
        cs_low();
        send_byte(8'hEB);
        send_addr_q(24'h000FFF);
        repeat (6) sclk_edge(4'h0);
        if (QUAD) begin
            exp_q.push_back(8'h77); exp_q.push_back(8'h88);
            exp_oe = 4'hF;
        end
        repeat (4) sclk_edge(4'h0);
        cs_high();

        // single read across the wrap: sees quad data only when quad exists
        if (QUAD) begin
            exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        end else begin
            exp_q.push_back(8'hE1); exp_q.push_back(8'h1E);
        end
        single_read(24'h000FFF, 2);

        // unknown opcode is ignored, then a normal read still works
        cs_low();
        send_byte(8'h9F);
        repeat (32) sclk_edge(4'hF);
        cs_high();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h3C);
        single_read(24'h000101, 2);

        // reset after 20 address bits with cs held low
        cs_low();
        send_byte(8'h03);
        for (int i = 23; i >= 4; i--) sclk_edge({3'b000, 1'b0 ^ (i == 8)});
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk_zero = 1'b1;
        wait_clk(1);
        check4("midrst_oe", spi_io_oe, 4'h0);
        check4("midrst_out", spi_io_out, 4'h0);
        repeat (4 + 16) sclk_edge(4'h0);
        cs_high();
        chk_zero = 1'b0;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        single_read(24'h000100, 2);

        wait_clk(8);
        vec_cnt++;
        if (exp_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL sb_drain: %0d bytes still expected, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI/QSPI target that answers the SoC's shared-SPI memory initiator from the far end of the bus, emulating a PSRAM-style device backed by an internal byte array. Used as a synthesizable stand-in for external PSRAM in FPGA bring-up and as the bus partner in SoC-level benches. Oversamples `spi_sclk`/`spi_cs_n` on the system clock, decodes command/address/dummy/data phases, and drives read data back on the IO lines.

## Interface

Parameters:

- `MEM_BYTES`, default 4096: depth of the backing byte array. Must be a power of two.
- `DUMMY_CYCLES`, default 6: wait clocks between address and data for quad read (0xEB).

Ports:

- `clk` input 1: system clock. Must be ≥ 4× `spi_sclk` frequency.
- `rst` input 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `spi_cs_n` input 1: chip select, active low, from the initiator (`ram_cs_n` side).
- `spi_sclk` input 1: SPI clock, mode 0.
- `spi_io_in` input 4: IO lines as seen by this target.
- `spi_io_out` output 4: IO lines driven by this target.
- `spi_io_oe` output 4: per-line output enable.
- `load_en` input 1: backdoor byte write (bench/preload), sampled on `clk`.
- `load_addr` input 24: backdoor address, taken modulo `MEM_BYTES`.
- `load_data` input 8: backdoor data.

## Operation

- `spi_cs_n`, `spi_sclk`, and `spi_io_in` pass through 2-flop synchronizers. Rising and falling `spi_sclk` edges are detected in the `clk` domain.
- Mode 0 timing. Input bits are sampled on the detected rising edge. Output bits update on the detected falling edge. All transfers are MSB first.
- States:
  - `IDLE`: `spi_cs_n` low moves to `CMD`.
  - `CMD`: 8 bits on io[0]. Decode:
    - 0x03 single read or 0x02 single write: go to `ADDR`, 1 bit per edge.
    - 0xEB quad read or 0x38 quad write: go to `ADDR`, 4 bits per edge.
    - Any other opcode: go to `IGNORE`.
  - `ADDR`: 24 bits. Single mode uses 24 edges; quad mode uses 6 edges on io[3:0]. The address is latched modulo `MEM_BYTES`. After the address, 0xEB goes to `DUMMY`, reads go to `RDATA`, and writes go to `WDATA`.
  - `DUMMY`: counts `DUMMY_CYCLES` rising edges, then goes to `RDATA`.
  - `RDATA`:
    - Single mode drives io[1] with `spi_io_oe`=4'b0010.
    - Quad mode drives io[3:0] high nibble first with `spi_io_oe`=4'hF.
    - After each byte the address increments and the next byte is fetched.
  - `WDATA`: assembles bytes from io[0] (single) or io[3:0] (quad). The byte is written on the rising edge that completes it, then the address increments.
  - `IGNORE`: `spi_io_oe`=0 until `spi_cs_n` rises.
- `spi_cs_n` high, as detected by the synchronizer, forces `IDLE` from any state in the same cycle. It also clears the bit counter and sets `spi_io_oe`=0. A partial write byte is discarded.
- Address wraps from `MEM_BYTES-1` to 0.
- Backdoor `load_en` writes in one cycle. If it coincides with an SPI write to the same address, the SPI write wins.
- Reset while `spi_cs_n` is low:
  - The block enters `IDLE`, but the in-flight transaction is not joined.
  - The block waits for `spi_cs_n` high before accepting a command.
  - Memory contents are not cleared by reset.

## Timing

- Reset values: `spi_io_out`=4'h0, `spi_io_oe`=4'h0, state `IDLE`, counters 0.
- Input latency: 2 synchronizer cycles plus 1 edge-detect cycle. A `spi_sclk` edge acts ≤3 `clk` after the pin change.
- First read bit:
  - Single read (0x03): driven after the falling edge following the 32nd rising edge.
  - Quad read (0xEB): driven after the falling edge following rising edge 8+6+`DUMMY_CYCLES`.
  - In both cases it is valid ≤3 `clk` after that falling edge.
- `spi_io_oe` asserts together with the first data bit and deasserts ≤3 `clk` after `spi_cs_n` rises.
- Write commit is visible to the backdoor/readback 1 `clk` after the completing rising edge.

## Configuration

- `SPI_RESP_QUAD_EN`:
  - Defined: 0xEB and 0x38 are decoded as described, and `DUMMY` is present.
  - Undefined: 0xEB and 0x38 go to `IGNORE`. io[3:2] are never driven. `spi_io_oe` is restricted to 4'b0000/4'b0010, and the `DUMMY` state and counter are removed.

## Structure

- Package `spi_resp_pkg` holds:
  - the opcode constants (`CMD_READ`=8'h03, `CMD_WRITE`=8'h02, `CMD_QREAD`=8'hEB, `CMD_QWRITE`=8'h38);
  - the state enum (`IDLE`, `CMD`, `ADDR`, `DUMMY`, `RDATA`, `WDATA`, `IGNORE`);
  - the address width constant (24).
- One sub-module, `spi_edge_sync`: 2-flop synchronizers plus rise/fall detect for `spi_sclk`, and a synchronized level for `spi_cs_n`. Instantiated once.

## Test plan

- Backdoor-load 0x100..0x103 = A5 5A 3C C3, then single read 0x03 @0x000100 for 4 bytes. io[1] must return A5 5A 3C C3, with `spi_io_oe`=4'b0010 only during data.
- Single write 0x02 @0x000010 of bytes 11 22, then single read of the same address. The read must return 11 22. A partial 3rd byte (4 bits, then `spi_cs_n` high) must leave 0x012 unchanged.
- Quad write 0x38 @0x000FFF of 77 88, then quad read 0xEB @0x000FFF with 6 dummy cycles. The read must return 77 88, confirming wrap (0xFFF, then 0x000). `spi_io_oe`=4'hF during data. Without `SPI_RESP_QUAD_EN`, `spi_io_oe` must stay 0.
- Opcode 0x9F, then 32 clocks: `spi_io_oe` must stay 0 throughout. The next valid 0x03 after `spi_cs_n` toggles must read correctly.
- Assert `rst` mid-read after 20 address bits while `spi_cs_n` stays low: outputs must be 0 and `spi_io_oe`=0 until `spi_cs_n` high. After that, a new 0x03 read returns the preloaded data.
